// File: rtl/handshake_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : handshake_pkg
//  Description : Shared constants and sizing helpers for the elastic
//                handshake FIFO and its pointer sub-module.
//  Revision    : 1.0 - initial release
// ============================================================================
package handshake_pkg;

  // Token width used when an instance does not override DATA_WIDTH.
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Pointer width: enough bits to address DEPTH slots, never narrower than 1
  // so that a single-slot FIFO still has a legal (constant-zero) pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    int unsigned w;
    w = unsigned'($clog2(depth));
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy counter width: must represent every value 0..DEPTH inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return unsigned'($clog2(depth + 1));
  endfunction

endpackage : handshake_pkg
`default_nettype wire

// File: rtl/handshake_fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_fifo_ptr
//  Description : Wrap-around slot pointer for the handshake FIFO. Advances by
//                one on each clock edge where inc is high and returns to 0
//                after slot DEPTH-1, so any DEPTH (not only powers of two)
//                is supported.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset, clears ptr to 0
//                inc  - advance the pointer on this edge
//                ptr  - current slot index, 0..DEPTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_fifo_ptr
  import handshake_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] C_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] ptr_next;

  // Explicit compare-and-clear instead of natural binary rollover, because
  // DEPTH need not be a power of two.
  always_comb begin
    ptr_next = ptr;
    if (inc) begin
      if (ptr == C_LAST) begin
        ptr_next = '0;
      end else begin
        ptr_next = ptr + C_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule : handshake_fifo_ptr
`default_nettype wire

// File: rtl/handshake_fifo_break_dv.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_fifo_break_dv
//  Description : Elastic FIFO that breaks both the data and the valid path
//                between a dataflow producer and its consumer. Tokens are
//                always registered before they become visible (no bypass),
//                and ins_ready is derived from the registered occupancy only,
//                so no combinational path exists from any input to any output.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                ins        - input token data          (DATA_WIDTH)
//                ins_valid  - producer offers a token
//                ins_ready  - FIFO can accept a token (count != DEPTH)
//                outs       - head token data           (DATA_WIDTH)
//                outs_valid - FIFO holds a token       (count != 0)
//                outs_ready - consumer accepts the head token
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_fifo_break_dv
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic push;
  logic pop;

  // --------------------------------------------------------------------------
  // Handshake flags. Both ready and valid are functions of count alone; a
  // full FIFO refuses a push even if a pop frees a slot in the same cycle,
  // which is what keeps outs_ready off the ins_ready path.
  // --------------------------------------------------------------------------
  assign ins_ready  = (count != C_FULL);
  assign outs_valid = (count != '0);

  assign push = ins_valid & ins_ready;
  assign pop  = outs_valid & outs_ready;

  // Head data is a register mux; while empty it shows stale contents.
  assign outs = mem[rd_ptr];

  // --------------------------------------------------------------------------
  // Pointers
  // --------------------------------------------------------------------------
  handshake_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  handshake_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  // --------------------------------------------------------------------------
  // Storage. Entries are cleared on reset so outs reads 0 immediately after
  // reset rather than leaking a discarded token.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= ins;
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Internal consistency properties
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_count_range : assert property (@(posedge clk) disable iff (rst)
    count <= C_FULL);

  // Pointer distance modulo DEPTH must agree with occupancy.
  a_ptr_count : assert property (@(posedge clk) disable iff (rst)
    ((int'(wr_ptr) - int'(rd_ptr) + int'(DEPTH)) % int'(DEPTH))
      == (int'(count) % int'(DEPTH)));
`endif

endmodule : handshake_fifo_break_dv
`default_nettype wire

// File: tb/tb_handshake_fifo_break_dv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake_fifo_break_dv
//  Description : Self-checking bench for handshake_fifo_break_dv. Two
//                instances: A (8-bit, DEPTH 4) for directed scenarios and
//                B (16-bit, DEPTH 3) for random backpressure. Each has a
//                queue-based reference model of an ideal bounded FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_fifo_break_dv;

  localparam int A_DEPTH = 4;
  localparam int B_DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  a_ins = '0;
  logic        a_ins_valid = 1'b0;
  logic        a_ins_ready;
  logic [7:0]  a_outs;
  logic        a_outs_valid;
  logic        a_outs_ready = 1'b0;

  logic [15:0] b_ins = '0;
  logic        b_ins_valid = 1'b0;
  logic        b_ins_ready;
  logic [15:0] b_outs;
  logic        b_outs_valid;
  logic        b_outs_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0]  qa[$];
  logic [15:0] qb[$];
  bit a_push, a_pop, b_push, b_pop;

  always #5 clk = ~clk;

  handshake_fifo_break_dv #(.DATA_WIDTH(8), .DEPTH(A_DEPTH)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .ins        (a_ins),
    .ins_valid  (a_ins_valid),
    .ins_ready  (a_ins_ready),
    .outs       (a_outs),
    .outs_valid (a_outs_valid),
    .outs_ready (a_outs_ready)
  );

  handshake_fifo_break_dv #(.DATA_WIDTH(16), .DEPTH(B_DEPTH)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .ins        (b_ins),
    .ins_valid  (b_ins_valid),
    .ins_ready  (b_ins_ready),
    .outs       (b_outs),
    .outs_valid (b_outs_valid),
    .outs_ready (b_outs_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs against the model mid-cycle, decide the
  // handshakes from the model, then apply them at the rising edge.
  task automatic tick();
    @(negedge clk);
    check("a_ins_ready", 32'(a_ins_ready), 32'(qa.size() != A_DEPTH));
    check("a_outs_valid", 32'(a_outs_valid), 32'(qa.size() != 0));
    if (qa.size() != 0) check("a_outs", 32'(a_outs), 32'(qa[0]));
    check("b_ins_ready", 32'(b_ins_ready), 32'(qb.size() != B_DEPTH));
    check("b_outs_valid", 32'(b_outs_valid), 32'(qb.size() != 0));
    if (qb.size() != 0) check("b_outs", 32'(b_outs), 32'(qb[0]));
    a_push = a_ins_valid && (qa.size() != A_DEPTH);
    a_pop  = a_outs_ready && (qa.size() != 0);
    b_push = b_ins_valid && (qb.size() != B_DEPTH);
    b_pop  = b_outs_ready && (qb.size() != 0);
    @(posedge clk);
    if (a_pop)  void'(qa.pop_front());
    if (a_push) qa.push_back(a_ins);
    if (b_pop)  void'(qb.pop_front());
    if (b_push) qb.push_back(b_ins);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_valid"}, 32'(a_outs_valid), 32'd0);
    check({tag, "_a_ready"}, 32'(a_ins_ready), 32'd1);
    check({tag, "_a_outs"}, 32'(a_outs), 32'd0);
    check({tag, "_b_valid"}, 32'(b_outs_valid), 32'd0);
    check({tag, "_b_ready"}, 32'(b_ins_ready), 32'd1);
    check({tag, "_b_outs"}, 32'(b_outs), 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    bit saw_full_block;

    // Power-on reset
    #12;
    check_reset_outputs("rst0");
    rst = 1'b0;
    tick();

    // Single token latency: 0xEE visible one cycle after push, gone after pop
    a_ins = 8'hEE; a_ins_valid = 1'b1; a_outs_ready = 1'b1;
    tick();
    a_ins_valid = 1'b0;
    check("lat_visible", 32'(a_outs_valid), 32'd1);
    check("lat_data", 32'(a_outs), 32'hEE);
    tick();
    tick();

    // Fill and stall: push 0x01..0x05 with consumer stalled
    a_outs_ready = 1'b0;
    v = 8'h01;
    saw_full_block = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_ins = v; a_ins_valid = 1'b1;
      tick();
      if (a_push) v = v + 8'd1;
      else saw_full_block = 1'b1;
    end
    check("stall_held_off", 32'(v), 32'h05);
    check("stall_blocked", 32'(saw_full_block), 32'd1);
    a_outs_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (v == 8'h06) a_ins_valid = 1'b0;
      a_ins = v;
      tick();
      if (a_push) v = v + 8'd1;
    end
    a_ins_valid = 1'b0;
    check("stall_drained", 32'(qa.size()), 32'd0);

    // Full with simultaneous pop: pop happens, push refused
    a_outs_ready = 1'b0;
    for (int i = 0; i < A_DEPTH; i++) begin
      a_ins = 8'h40 + 8'(i); a_ins_valid = 1'b1;
      tick();
    end
    a_ins = 8'h80; a_outs_ready = 1'b1;
    tick();
    check("full_pop_count", 32'(qa.size()), 32'd3);
    a_outs_ready = 1'b0; a_ins_valid = 1'b0;
    tick();
    a_outs_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Asynchronous reset mid-cycle with two tokens held
    a_outs_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_ins = 8'hA0 + 8'(i); a_ins_valid = 1'b1;
      tick();
    end
    a_ins_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    qa.delete();
    qb.delete();
    #1 rst = 1'b0;
    a_outs_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Streaming: 20 cycles of continuous valid/ready, data from 0x10
    v = 8'h10;
    a_ins_valid = 1'b1; a_outs_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_ins = v;
      tick();
      if (a_push) v = v + 8'd1;
      if (i > 0) check("stream_count", 32'(qa.size()), 32'd1);
    end
    a_ins_valid = 1'b0;
    check("stream_last", 32'(v), 32'h24);
    tick();
    tick();

    // Random backpressure on the DEPTH-3 instance
    a_outs_ready = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      b_ins       = 16'($urandom);
      b_ins_valid = 1'($urandom_range(0, 1));
      b_outs_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        // ins_ready must not follow a mid-cycle change of outs_ready
        b_outs_ready = ~b_outs_ready;
        #1;
        check("b_ready_comb", 32'(b_ins_ready), 32'(qb.size() != B_DEPTH));
        b_outs_ready = ~b_outs_ready;
      end
      tick();
    end
    b_ins_valid = 1'b0; b_outs_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("b_drained", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_handshake_fifo_break_dv
`default_nettype wire
